// File: rtl/fetch_irq_sequencer.sv
// Front-end sequencing FSM: reset bubbles, long-immediate fetch, prioritised interrupt entry, stall/flush arbitration.
// Optional nested interrupt support is enabled by defining NESTED_IRQ_EN.
module fetch_irq_sequencer #(
    parameter int         NUM_IRQ      = 4,
    parameter int         IRQ_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    parameter int         IMM_WORDS    = 1,
    parameter int         INT_CYCLES   = 1,
    parameter int         RESET_CYCLES = 1,
    parameter logic [3:0] LONG_OPCODE  = 4'd12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [3:0]         opcode,
    input  logic [1:0]         ra,
    input  logic               stall_in,
    input  logic               flush_in,
    output logic               PC_Write_En,
    output logic               IF_ID_Write_En,
    output logic               Inject_Bubble,
    output logic               Inject_Int,
    output logic [IRQ_W-1:0]   int_vec_sel,
    output logic               int_push,
    output logic               int_active
);

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_FETCH_IMM,
        S_INTR
    } state_t;

    localparam logic [2:0] RST_LAST = 3'(RESET_CYCLES - 1);
    localparam logic [2:0] IMM_LAST = 3'(IMM_WORDS - 1);
    localparam logic [2:0] INT_LAST = 3'(INT_CYCLES - 1);

    state_t             state, state_next;
    logic [2:0]         cnt, cnt_next;
    logic [NUM_IRQ-1:0] pending, pending_next;
    logic [NUM_IRQ-1:0] irq_q, irq_rise;
    logic [NUM_IRQ-1:0] take_mask;
    logic [NUM_IRQ-1:0] lowest_onehot;
    logic [IRQ_W-1:0]   lowest_idx;
    logic               irq_allowed;
    logic               is_rti;

`ifdef NESTED_IRQ_EN
    logic [NUM_IRQ-1:0] in_service, in_service_next;
    logic               blocked;
`else
    logic               in_service, in_service_next;
`endif

    assign irq_rise = irq & ~irq_q;
    assign is_rti   = (opcode == 4'b1011) && (ra == 2'b11);

    // Lowest-index pending line wins; index 0 is highest priority.
    always_comb begin
        lowest_idx    = '0;
        lowest_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lowest_idx       = IRQ_W'(i);
                lowest_onehot    = '0;
                lowest_onehot[i] = 1'b1;
            end
        end
    end

`ifdef NESTED_IRQ_EN
    always_comb begin
        blocked = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (in_service[i] && (i <= int'(lowest_idx))) begin
                blocked = 1'b1;
            end
        end
    end

    assign irq_allowed = (pending != '0) && !blocked;
    assign int_active  = |in_service;
`else
    assign irq_allowed = (pending != '0) && !in_service;
    assign int_active  = in_service;
`endif

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        take_mask       = '0;
        in_service_next = in_service;
        PC_Write_En     = 1'b1;
        IF_ID_Write_En  = 1'b1;
        Inject_Bubble   = 1'b0;
        Inject_Int      = 1'b0;
        int_vec_sel     = '0;
        int_push        = 1'b0;

        case (state)
            S_RESET: begin
                Inject_Bubble = 1'b1;
                if (cnt == RST_LAST) begin
                    state_next = S_FETCH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end

            S_FETCH: begin
                if (flush_in) begin
                    Inject_Bubble = 1'b1;
                end else if (stall_in) begin
                    PC_Write_En    = 1'b0;
                    IF_ID_Write_En = 1'b0;
                    Inject_Bubble  = 1'b1;
                end else if (irq_allowed) begin
                    Inject_Int  = 1'b1;
                    int_vec_sel = lowest_idx;
                    take_mask   = lowest_onehot;
`ifdef NESTED_IRQ_EN
                    in_service_next = in_service | lowest_onehot;
`else
                    in_service_next = 1'b1;
`endif
                    state_next = S_INTR;
                    cnt_next   = '0;
                end else if (opcode == LONG_OPCODE) begin
                    IF_ID_Write_En = 1'b0;
                    Inject_Bubble  = 1'b1;
                    state_next     = S_FETCH_IMM;
                    cnt_next       = '0;
                end else if (is_rti) begin
`ifdef NESTED_IRQ_EN
                    // Clear only the most recently nested (lowest-index) level.
                    in_service_next = in_service & (in_service - 1'b1);
`else
                    in_service_next = 1'b0;
`endif
                end
            end

            S_FETCH_IMM: begin
                if (flush_in) begin
                    Inject_Bubble = 1'b1;
                    state_next    = S_FETCH;
                    cnt_next      = '0;
                end else if (stall_in) begin
                    PC_Write_En    = 1'b0;
                    IF_ID_Write_En = 1'b0;
                end else if (cnt < IMM_LAST) begin
                    IF_ID_Write_En = 1'b0;
                    Inject_Bubble  = 1'b1;
                    cnt_next       = cnt + 3'd1;
                end else begin
                    state_next = S_FETCH;
                    cnt_next   = '0;
                end
            end

            S_INTR: begin
                int_push      = 1'b1;
                Inject_Bubble = 1'b1;
                if (cnt == INT_LAST) begin
                    state_next = S_FETCH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end

            default: begin
                state_next = S_RESET;
                cnt_next   = '0;
            end
        endcase
    end

    // A new edge on the line being taken this cycle is dropped; other lines still latch.
    assign pending_next = (pending | irq_rise) & ~take_mask;

    always_ff @(posedge clk) begin
        irq_q <= irq;
        if (rst) begin
            state      <= S_RESET;
            cnt        <= '0;
            pending    <= '0;
            in_service <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            pending    <= pending_next;
            in_service <= in_service_next;
        end
    end

endmodule

// File: tb/tb_fetch_irq_sequencer.sv
// Scoreboard bench for fetch_irq_sequencer: directed scenarios plus random traffic against a behavioural model.
// Honours NESTED_IRQ_EN in the model when the design is built with it.
module tb_fetch_irq_sequencer;

    localparam int NUM_IRQ      = 4;
    localparam int IRQ_W        = 2;
    localparam int IMM_WORDS    = 3;
    localparam int INT_CYCLES   = 2;
    localparam int RESET_CYCLES = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_IRQ-1:0] irq;
    logic [3:0]         opcode;
    logic [1:0]         ra;
    logic               stall_in;
    logic               flush_in;
    logic               PC_Write_En;
    logic               IF_ID_Write_En;
    logic               Inject_Bubble;
    logic               Inject_Int;
    logic [IRQ_W-1:0]   int_vec_sel;
    logic               int_push;
    logic               int_active;

    fetch_irq_sequencer #(
        .NUM_IRQ(NUM_IRQ),
        .IRQ_W(IRQ_W),
        .IMM_WORDS(IMM_WORDS),
        .INT_CYCLES(INT_CYCLES),
        .RESET_CYCLES(RESET_CYCLES),
        .LONG_OPCODE(4'd12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq(irq),
        .opcode(opcode),
        .ra(ra),
        .stall_in(stall_in),
        .flush_in(flush_in),
        .PC_Write_En(PC_Write_En),
        .IF_ID_Write_En(IF_ID_Write_En),
        .Inject_Bubble(Inject_Bubble),
        .Inject_Int(Inject_Int),
        .int_vec_sel(int_vec_sel),
        .int_push(int_push),
        .int_active(int_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       ifw;
        logic       bub;
        logic       inj;
        logic [1:0] sel;
        logic       push;
        logic       act;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle_no = 0;

    // Model: remaining bubble counts instead of an explicit state.
    bit       m_known   = 1'b0;
    int       rst_left  = 0;
    int       intr_left = 0;
    int       imm_pos   = -1;
    bit [3:0] m_pend    = '0;
    bit [3:0] m_prev    = '0;
`ifdef NESTED_IRQ_EN
    bit [3:0] m_srv     = '0;
`else
    bit       m_srv     = 1'b0;
`endif

    task automatic checkOutput(input exp_t e);
        exp_t got;
        got.pcw  = PC_Write_En;
        got.ifw  = IF_ID_Write_En;
        got.bub  = Inject_Bubble;
        got.inj  = Inject_Int;
        got.sel  = Inject_Int ? int_vec_sel : 2'b00;
        got.push = int_push;
        got.act  = int_active;
        n_checks++;
        if (got === e) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL outputs cycle %0d: got pcw=%b ifw=%b bub=%b inj=%b sel=%0d push=%b act=%b, want pcw=%b ifw=%b bub=%b inj=%b sel=%0d push=%b act=%b",
                     cycle_no, got.pcw, got.ifw, got.bub, got.inj, got.sel, got.push, got.act,
                     e.pcw, e.ifw, e.bub, e.inj, e.sel, e.push, e.act);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            checkOutput(sb.pop_front());
        end
    end

    task automatic applyStimulus(input bit r, input bit [3:0] i, input bit [3:0] op,
                                 input bit [1:0] a, input bit s, input bit f);
        exp_t     e;
        int       n_rst, n_intr, n_imm, lo, take;
        bit       blk;
        bit [3:0] n_pend;
`ifdef NESTED_IRQ_EN
        bit [3:0] n_srv;
`else
        bit       n_srv;
`endif
        rst = r; irq = i; opcode = op; ra = a; stall_in = s; flush_in = f;

        e = '{pcw: 1'b1, ifw: 1'b1, bub: 1'b0, inj: 1'b0, sel: 2'b00, push: 1'b0, act: (m_srv != 0)};
        n_rst = rst_left; n_intr = intr_left; n_imm = imm_pos; n_srv = m_srv; take = -1;
        lo = -1;
        for (int k = 3; k >= 0; k--) if (m_pend[k]) lo = k;

        if (rst_left > 0) begin
            e.bub = 1'b1;
            n_rst = rst_left - 1;
        end else if (intr_left > 0) begin
            e.push = 1'b1;
            e.bub  = 1'b1;
            n_intr = intr_left - 1;
        end else if (imm_pos >= 0) begin
            if (f) begin
                e.bub = 1'b1;
                n_imm = -1;
            end else if (s) begin
                e.pcw = 1'b0;
                e.ifw = 1'b0;
            end else if (imm_pos < IMM_WORDS - 1) begin
                e.ifw = 1'b0;
                e.bub = 1'b1;
                n_imm = imm_pos + 1;
            end else begin
                n_imm = -1;
            end
        end else begin
`ifdef NESTED_IRQ_EN
            blk = 1'b0;
            for (int k = 0; k <= lo; k++) if (m_srv[k]) blk = 1'b1;
`else
            blk = m_srv;
`endif
            if (f) begin
                e.bub = 1'b1;
            end else if (s) begin
                e.pcw = 1'b0;
                e.ifw = 1'b0;
                e.bub = 1'b1;
            end else if (lo >= 0 && !blk) begin
                e.inj  = 1'b1;
                e.sel  = 2'(lo);
                take   = lo;
                n_intr = INT_CYCLES;
`ifdef NESTED_IRQ_EN
                n_srv[lo] = 1'b1;
`else
                n_srv = 1'b1;
`endif
            end else if (op == 4'd12) begin
                e.ifw = 1'b0;
                e.bub = 1'b1;
                n_imm = 0;
            end else if (op == 4'd11 && a == 2'd3) begin
`ifdef NESTED_IRQ_EN
                for (int k = 3; k >= 0; k--) if (m_srv[k]) lo = k;
                if (m_srv != 0) begin
                    lo = 0;
                    while (!m_srv[lo]) lo++;
                    n_srv[lo] = 1'b0;
                end
`else
                n_srv = 1'b0;
`endif
            end
        end

        n_pend = m_pend | (i & ~m_prev);
        if (take >= 0) n_pend[take] = 1'b0;

        if (m_known) sb.push_back(e);

        @(posedge clk);
        cycle_no++;
        m_prev = i;
        if (r) begin
            m_known = 1'b1; rst_left = RESET_CYCLES; intr_left = 0; imm_pos = -1;
            m_pend = '0; m_srv = '0;
        end else if (m_known) begin
            rst_left = n_rst; intr_left = n_intr; imm_pos = n_imm;
            m_pend = n_pend; m_srv = n_srv;
        end
        #1;
    endtask

    task automatic idle(input int n, input bit [3:0] i);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, i, 4'd0, 2'd0, 1'b0, 1'b0);
    endtask

    bit [3:0] irq_v;
    bit [3:0] op_v;

    initial begin
        // Reset held three cycles, then the two bubble cycles.
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 4'b0, 4'd0, 2'd0, 1'b0, 1'b0);
        idle(4, 4'b0);

        // Long instruction with immediate words.
        applyStimulus(1'b0, 4'b0, 4'd12, 2'd0, 1'b0, 1'b0);
        idle(5, 4'b0);

        // Two lines rising together, line 1 first, line 2 after RTI.
        idle(6, 4'b0110);
        applyStimulus(1'b0, 4'b0110, 4'd11, 2'd3, 1'b0, 1'b0);
        idle(5, 4'b0110);
        applyStimulus(1'b0, 4'b0000, 4'd11, 2'd3, 1'b0, 1'b0);
        idle(2, 4'b0);

        // Stall holds off a pending interrupt.
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'b0001, 4'd0, 2'd0, 1'b1, 1'b0);
        idle(4, 4'b0001);
        applyStimulus(1'b0, 4'b0000, 4'd11, 2'd3, 1'b0, 1'b0);

        // Flush during the immediate fetch.
        applyStimulus(1'b0, 4'b0, 4'd12, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0, 4'd0, 2'd0, 1'b0, 1'b1);
        idle(3, 4'b0);

        // Reset during interrupt entry.
        idle(1, 4'b1000);
        applyStimulus(1'b0, 4'b1000, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1000, 4'd0, 2'd0, 1'b0, 1'b0);
        idle(4, 4'b1000);

        irq_v = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 11) == 0) irq_v[b] = ~irq_v[b];
            case ($urandom_range(0, 9))
                0:       op_v = 4'd12;
                1, 2:    op_v = 4'd11;
                default: op_v = 4'($urandom_range(0, 15));
            endcase
            applyStimulus($urandom_range(0, 249) == 0, irq_v, op_v, 2'($urandom_range(0, 3)),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("[TB] FAIL scoreboard drain: %0d entries left, want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
